vga_timing_gen: RTL and testbench

Parametrised VGA timing and test-pattern generator for the display path. It derives a pixel-clock enable from the system clock and runs horizontal/vertical counters for any timing set. It emits registered, polarity-configurable sync, data-enable, and line/frame strobes, plus RGB 3:3:2 from one of four pattern modes. It replaces the fixed 640x480 controller and serves as the timing master for downstream frame-buffer readers.

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/vga_axis_counter.sv | 35 +++
 rtl/vga_timing_gen.sv | 170 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA timing / test-pattern generator.
//   rgb332_t : packed {r[2:0], g[2:0], b[1:0]} pixel
//   mode_e   : pattern select (solid, checker, colour bars, external)
//   BAR_*    : colour-bar palette, BAR_TABLE indexed by bar number 0..7
//   VGA640_* : 640x480@60 default timing
package vga_pkg;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb332_t;

   typedef enum logic [1:0] {
      MODE_SOLID   = 2'd0,
      MODE_CHECKER = 2'd1,
      MODE_BARS    = 2'd2,
      MODE_EXT     = 2'd3
   } mode_e;

   localparam logic [7:0] BAR_WHITE   = 8'hFF;
   localparam logic [7:0] BAR_YELLOW  = 8'hFC;
   localparam logic [7:0] BAR_CYAN    = 8'h1F;
   localparam logic [7:0] BAR_GREEN   = 8'h1C;
   localparam logic [7:0] BAR_MAGENTA = 8'hE3;
   localparam logic [7:0] BAR_RED     = 8'hE0;
   localparam logic [7:0] BAR_BLUE    = 8'h03;
   localparam logic [7:0] BAR_BLACK   = 8'h00;

   // Element [0] is the leftmost bar.
   localparam logic [7:0][7:0] BAR_TABLE = {BAR_BLACK, BAR_BLUE, BAR_RED, BAR_MAGENTA,
                                            BAR_GREEN, BAR_CYAN, BAR_YELLOW, BAR_WHITE};

   localparam int VGA640_H_VIS  = 640;
   localparam int VGA640_H_FP   = 16;
   localparam int VGA640_H_SYNC = 96;
   localparam int VGA640_H_BP   = 48;
   localparam int VGA640_V_VIS  = 480;
   localparam int VGA640_V_FP   = 10;
   localparam int VGA640_V_SYNC = 2;
   localparam int VGA640_V_BP   = 33;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one display axis.
//   clk, rst_n : system clock, async active-low reset
//   inc        : advance by one this clk
//   cnt        : current position 0..TOTAL-1
//   wrap       : inc while at TOTAL-1 (counter returns to 0 on this edge)
module vga_axis_counter #(
   parameter int TOTAL = 800,
   parameter int W     = $clog2(TOTAL)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(TOTAL - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign wrap = inc && (cnt_q == LAST);
   assign cnt  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (wrap)     cnt_d = '0;
      else if (inc) cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing master and test-pattern generator.
//   clk, rst_n        : system clock, async active-low reset
//   mode, fg_rgb      : pattern select (frame-latched) and foreground colour
//   ext_rgb           : external pixel for the coordinate on x/y (mode 3)
//   pix_ce            : pixel-clock enable, one clk per CLK_DIV clks
//   x, y              : stage-0 fetch coordinates
//   hsync, vsync, de  : stage-1 registered timing, one pixel behind x/y
//   line_start, frame_start : one-clk strobes after the pix_ce edge at x==0 (and y==0)
//   vga_red/green/blue: stage-1 RGB 3:3:2, zero outside the visible area
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int H_VIS    = VGA640_H_VIS,
   parameter int H_FP     = VGA640_H_FP,
   parameter int H_SYNC   = VGA640_H_SYNC,
   parameter int H_BP     = VGA640_H_BP,
   parameter int V_VIS    = VGA640_V_VIS,
   parameter int V_FP     = VGA640_V_FP,
   parameter int V_SYNC   = VGA640_V_SYNC,
   parameter int V_BP     = VGA640_V_BP,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   parameter int CHK_LOG2 = 5,
   parameter int XW       = $clog2(H_VIS + H_FP + H_SYNC + H_BP),
   parameter int YW       = $clog2(V_VIS + V_FP + V_SYNC + V_BP)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    mode,
   input  logic [7:0]    fg_rgb,
   input  logic [7:0]    ext_rgb,
   output logic          pix_ce,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic          line_start,
   output logic          frame_start,
   output logic [2:0]    vga_red,
   output logic [2:0]    vga_green,
   output logic [1:0]    vga_blue
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int DIVW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BAR_W   = H_VIS / 8;
   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);

   generate
      if ((H_VIS % 8) != 0) begin : g_bad_hvis
         $error("vga_timing_gen: H_VIS must be a multiple of 8");
      end
      if (CLK_DIV < 1) begin : g_bad_div
         $error("vga_timing_gen: CLK_DIV must be at least 1");
      end
   endgenerate

   logic [DIVW-1:0] div_q, div_d;
   logic            pix_ce_w;
   logic [XW-1:0]   x_w;
   logic [YW-1:0]   y_w;
   logic            h_wrap, v_wrap_unused;

   // With CLK_DIV=1 div_q stays 0 == DIV_LAST, so pix_ce is held high.
   assign pix_ce_w = (div_q == DIV_LAST);
   assign div_d    = pix_ce_w ? '0 : div_q + DIVW'(1);

   vga_axis_counter #(.TOTAL(H_TOTAL), .W(XW)) u_h_cnt (
      .clk(clk), .rst_n(rst_n), .inc(pix_ce_w), .cnt(x_w), .wrap(h_wrap)
   );

   vga_axis_counter #(.TOTAL(V_TOTAL), .W(YW)) u_v_cnt (
      .clk(clk), .rst_n(rst_n), .inc(h_wrap), .cnt(y_w), .wrap(v_wrap_unused)
   );

   logic    vis, h_in_sync, v_in_sync, at_origin, chk_bit;
   logic [2:0] bar_idx;
   logic [XW-1:0] x_sh;
   logic [YW-1:0] y_sh;
   mode_e   mode_eff;
   rgb332_t pat;

   mode_e   mode_q, mode_d;
   logic    de_q, de_d, hs_q, hs_d, vs_q, vs_d, ls_q, ls_d, fs_q, fs_d;
   rgb332_t rgb_q, rgb_d;

   always_comb begin
      vis       = (int'(x_w) < H_VIS) && (int'(y_w) < V_VIS);
      h_in_sync = (int'(x_w) >= H_VIS + H_FP) && (int'(x_w) < H_VIS + H_FP + H_SYNC);
      v_in_sync = (int'(y_w) >= V_VIS + V_FP) && (int'(y_w) < V_VIS + V_FP + V_SYNC);
      at_origin = (x_w == '0) && (y_w == '0);
      x_sh      = x_w >> CHK_LOG2;
      y_sh      = y_w >> CHK_LOG2;
      chk_bit   = x_sh[0] ^ y_sh[0];

      bar_idx = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (int'(x_w) >= i * BAR_W) bar_idx = 3'(i);
      end

      // The origin pixel is the first one of the new frame, so it already
      // uses the mode being latched on this edge.
      mode_eff = at_origin ? mode_e'(mode) : mode_q;

      pat = '0;
      case (mode_eff)
         MODE_SOLID:   pat = fg_rgb;
         MODE_CHECKER: pat = chk_bit ? rgb332_t'(fg_rgb) : rgb332_t'(8'h00);
         MODE_BARS:    pat = BAR_TABLE[bar_idx];
         MODE_EXT:     pat = ext_rgb;
         default:      pat = '0;
      endcase
   end

   always_comb begin
      mode_d = mode_q;
      de_d   = de_q;
      hs_d   = hs_q;
      vs_d   = vs_q;
      rgb_d  = rgb_q;
      if (pix_ce_w) begin
         de_d  = vis;
         hs_d  = h_in_sync ? H_POL : ~H_POL;
         vs_d  = v_in_sync ? V_POL : ~V_POL;
         rgb_d = vis ? pat : '0;
         if (at_origin) mode_d = mode_e'(mode);
      end
      // Strobes are re-evaluated every clk so they stay one clk wide.
      ls_d = pix_ce_w && (x_w == '0);
      fs_d = ls_d && (y_w == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         mode_q <= MODE_SOLID;
         de_q   <= 1'b0;
         hs_q   <= ~H_POL;
         vs_q   <= ~V_POL;
         ls_q   <= 1'b0;
         fs_q   <= 1'b0;
         rgb_q  <= '0;
      end else begin
         div_q  <= div_d;
         mode_q <= mode_d;
         de_q   <= de_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         ls_q   <= ls_d;
         fs_q   <= fs_d;
         rgb_q  <= rgb_d;
      end
   end

   assign pix_ce      = pix_ce_w;
   assign x           = x_w;
   assign y           = y_w;
   assign hsync       = hs_q;
   assign vsync       = vs_q;
   assign de          = de_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;
   assign vga_red     = rgb_q.r;
   assign vga_green   = rgb_q.g;
   assign vga_blue    = rgb_q.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out waiting for DUT event", name);
   endtask

   // ---------------- default 640x480 instance ----------------
   logic [1:0] mode_def = 2'd0;
   logic [7:0] fg_def   = 8'hFF;
   logic [7:0] ext_def  = 8'h00;
   logic       pix_ce_def_unused, vsync_def_unused, ls_def_unused, fs_def_unused;
   logic [9:0] x_def_unused, y_def_unused;
   logic       hsync_def, de_def;
   logic [2:0] r_def, g_def;
   logic [1:0] b_def;
   logic [7:0] rgb_def;
   assign rgb_def = {r_def, g_def, b_def};

   vga_timing_gen dut_def (
      .clk(clk), .rst_n(rst_n), .mode(mode_def), .fg_rgb(fg_def), .ext_rgb(ext_def),
      .pix_ce(pix_ce_def_unused), .x(x_def_unused), .y(y_def_unused),
      .hsync(hsync_def), .vsync(vsync_def_unused), .de(de_def),
      .line_start(ls_def_unused), .frame_start(fs_def_unused),
      .vga_red(r_def), .vga_green(g_def), .vga_blue(b_def)
   );

   // ---------------- reduced-size instance A (CLK_DIV=4) ----------------
   // H 64/4/8/4 = 80, V 34/2/2/2 = 40 -> XW=7, YW=6, bars 8 px wide.
   logic [1:0] mode_a;
   logic [7:0] fg_a;
   logic [7:0] ext_a;
   logic       pix_ce_a, hsync_a, vsync_a, de_a, ls_a, fs_a;
   logic [6:0] x_a;
   logic [5:0] y_a;
   logic [2:0] r_a, g_a;
   logic [1:0] b_a;
   logic [7:0] rgb_a;
   assign rgb_a = {r_a, g_a, b_a};
   assign ext_a = {1'b0, x_a};

   vga_timing_gen #(
      .CLK_DIV(4), .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_VIS(34), .V_FP(2), .V_SYNC(2), .V_BP(2), .CHK_LOG2(5)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .mode(mode_a), .fg_rgb(fg_a), .ext_rgb(ext_a),
      .pix_ce(pix_ce_a), .x(x_a), .y(y_a), .hsync(hsync_a), .vsync(vsync_a), .de(de_a),
      .line_start(ls_a), .frame_start(fs_a),
      .vga_red(r_a), .vga_green(g_a), .vga_blue(b_a)
   );

   // ---------------- tiny instance B (CLK_DIV=1, active-high syncs) ----------------
   logic [1:0] mode_b = 2'd0;
   logic [7:0] fg_b   = 8'h5A;
   logic [7:0] ext_b  = 8'h00;
   logic       pix_ce_b, hsync_b, vsync_b, de_b, ls_b, fs_b;
   logic [3:0] x_b;
   logic [2:0] y_b_unused;
   logic [2:0] r_b, g_b;
   logic [1:0] b_b;
   logic [7:0] rgb_b;
   assign rgb_b = {r_b, g_b, b_b};

   vga_timing_gen #(
      .CLK_DIV(1), .H_VIS(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .mode(mode_b), .fg_rgb(fg_b), .ext_rgb(ext_b),
      .pix_ce(pix_ce_b), .x(x_b), .y(y_b_unused), .hsync(hsync_b), .vsync(vsync_b), .de(de_b),
      .line_start(ls_b), .frame_start(fs_b),
      .vga_red(r_b), .vga_green(g_b), .vga_blue(b_b)
   );

   // Stop at the negedge just before the pix_ce edge that registers (px,py) on A.
   task automatic wait_pix(input logic [6:0] px, input logic [5:0] py);
      int n = 0;
      while (!(pix_ce_a === 1'b1 && x_a == px && y_a == py) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20000) timeout_fail("wait_pix");
   endtask

   typedef struct {
      logic [1:0] mode;
      logic [7:0] fg;
      logic [6:0] px;
      logic [5:0] py;
      logic [7:0] rgb;
      logic       de;
   } vec_t;

   localparam int NV = 19;
   vec_t vec [NV];

   task automatic run_def();
      int   n, low, de_cnt, bad_rgb;
      logic seen_high;
      n = 0;
      while (hsync_def !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
      if (n >= 5000) timeout_fail("def_hsync_fall");
      n = 0; low = 0; de_cnt = 0; bad_rgb = 0; seen_high = 1'b0;
      while (n < 4000) begin
         if (!hsync_def) low++; else seen_high = 1'b1;
         if (de_def) de_cnt++;
         if (rgb_def !== (de_def ? 8'hFF : 8'h00)) bad_rgb++;
         @(negedge clk);
         n++;
         if (seen_high && !hsync_def) break;
      end
      check("def_hsync_period", 32'(n), 32'd3200);
      check("def_hsync_low",    32'(low), 32'd384);
      check("def_de_clks",      32'(de_cnt), 32'd2560);
      check("def_rgb_vs_de",    32'(bad_rgb), 32'd0);
   endtask

   task automatic run_b();
      int n, ls, vs, dec, hs_bad, misc_bad;
      n = 0;
      while (fs_b !== 1'b1 && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) timeout_fail("b_first_frame");
      n = 0;
      do begin @(negedge clk); n++; end while (fs_b !== 1'b1 && n < 500);
      check("b_frame_period", 32'(n), 32'd84);
      ls = 0; vs = 0; dec = 0; hs_bad = 0; misc_bad = 0;
      for (int k = 0; k < 84; k++) begin
         if (ls_b) ls++;
         if (vsync_b) vs++;
         if (de_b) dec++;
         // hsync shows the region of the previous x, so x_b 10..11 <-> sync at 9..10
         if (hsync_b !== ((x_b == 4'd10) || (x_b == 4'd11))) hs_bad++;
         if ((fs_b && !ls_b) || pix_ce_b !== 1'b1 || rgb_b !== (de_b ? 8'h5A : 8'h00)) misc_bad++;
         @(negedge clk);
      end
      check("b_line_starts", 32'(ls), 32'd7);
      check("b_vsync_clks",  32'(vs), 32'd12);
      check("b_de_clks",     32'(dec), 32'd32);
      check("b_hsync_pos",   32'(hs_bad), 32'd0);
      check("b_misc",        32'(misc_bad), 32'd0);
      n = 0;
      while (ls_b !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      n = 0;
      do begin @(negedge clk); n++; end while (ls_b !== 1'b1 && n < 100);
      check("b_line_period", 32'(n), 32'd12);
   endtask

   task automatic run_a();
      logic [1:0] cur_mode;
      // frame 0: solid mode, origin pixel and strobes
      wait_pix(7'd0, 6'd0);
      @(negedge clk);
      check("a_origin_rgb", 32'(rgb_a), 32'h0FF);
      check("a_origin_de",  32'(de_a), 32'd1);
      check("a_frame_start", 32'(fs_a), 32'd1);
      check("a_line_start",  32'(ls_a), 32'd1);
      @(negedge clk);
      check("a_fs_one_clk", 32'(fs_a), 32'd0);
      // mid-frame switch to checker must not affect the current frame
      wait_pix(7'd0, 6'd20);
      mode_a = 2'd1;
      wait_pix(7'd0, 6'd30);
      @(negedge clk);
      check("a_mode_held", 32'(rgb_a), 32'h0FF);
      cur_mode = 2'd0;
      for (int i = 0; i < NV; i++) begin
         fg_a = vec[i].fg;
         if (vec[i].mode != cur_mode) begin
            mode_a = vec[i].mode;
            wait_pix(7'd0, 6'd0);
            cur_mode = vec[i].mode;
         end
         wait_pix(vec[i].px, vec[i].py);
         @(negedge clk);
         check($sformatf("vec%0d_rgb", i), 32'(rgb_a), 32'(vec[i].rgb));
         check($sformatf("vec%0d_de", i),  32'(de_a),  32'(vec[i].de));
      end
   endtask

   initial begin
      //           mode   fg     px     py     rgb    de
      vec[0]  = '{2'd1, 8'hFF, 7'd0,  6'd0,  8'h00, 1'b1};
      vec[1]  = '{2'd1, 8'hFF, 7'd32, 6'd0,  8'hFF, 1'b1};
      vec[2]  = '{2'd1, 8'h1C, 7'd32, 6'd1,  8'h1C, 1'b1};
      vec[3]  = '{2'd1, 8'h1C, 7'd0,  6'd32, 8'h1C, 1'b1};
      vec[4]  = '{2'd1, 8'h1C, 7'd32, 6'd32, 8'h00, 1'b1};
      vec[5]  = '{2'd2, 8'h00, 7'd0,  6'd0,  8'hFF, 1'b1};
      vec[6]  = '{2'd2, 8'h00, 7'd7,  6'd0,  8'hFF, 1'b1};
      vec[7]  = '{2'd2, 8'h00, 7'd8,  6'd0,  8'hFC, 1'b1};
      vec[8]  = '{2'd2, 8'h00, 7'd20, 6'd0,  8'h1F, 1'b1};
      vec[9]  = '{2'd2, 8'h00, 7'd40, 6'd1,  8'hE0, 1'b1};
      vec[10] = '{2'd2, 8'h00, 7'd48, 6'd2,  8'h03, 1'b1};
      vec[11] = '{2'd2, 8'h00, 7'd63, 6'd2,  8'h00, 1'b1};
      vec[12] = '{2'd2, 8'h00, 7'd64, 6'd2,  8'h00, 1'b0};
      vec[13] = '{2'd0, 8'h5A, 7'd10, 6'd0,  8'h5A, 1'b1};
      vec[14] = '{2'd0, 8'h5A, 7'd70, 6'd5,  8'h00, 1'b0};
      vec[15] = '{2'd0, 8'h5A, 7'd10, 6'd34, 8'h00, 1'b0};
      vec[16] = '{2'd3, 8'h00, 7'd5,  6'd3,  8'h05, 1'b1};
      vec[17] = '{2'd3, 8'h00, 7'd63, 6'd3,  8'h3F, 1'b1};
      vec[18] = '{2'd3, 8'h00, 7'd64, 6'd3,  8'h00, 1'b0};

      rst_n  = 1'b0;
      mode_a = 2'd0;
      fg_a   = 8'hFF;
      repeat (3) @(negedge clk);
      check("rst_a_hsync", 32'(hsync_a), 32'd1);
      check("rst_a_rgb",   32'(rgb_a), 32'd0);
      check("rst_b_syncs", 32'({hsync_b, vsync_b}), 32'd0);
      rst_n = 1'b1;

      fork
         run_def();
         run_b();
         run_a();
      join

      // reset asserted mid-frame on A at (30,20) in external mode
      wait_pix(7'd30, 6'd20);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_xy",      32'({x_a, y_a}), 32'd0);
      check("rst_mid_rgb_de",  32'({rgb_a, de_a}), 32'd0);
      check("rst_mid_syncs",   32'({hsync_a, vsync_a}), 32'b11);
      check("rst_mid_strobes", 32'({ls_a, fs_a, pix_ce_a}), 32'd0);
      check("rst_mid_b_hsync", 32'(hsync_b), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int n = 0;
         while (n < 20) begin
            @(posedge clk);
            n++;
            #1;
            if (x_a == 7'd1) break;
         end
         check("first_pix_ce_edge", 32'(n), 32'd4);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
